// File: rtl/two_min_pkg.sv
// rtl/two_min_pkg.sv - shared types and constants for the two-minimum search controller
//
// Purpose: FSM state encoding, default datapath widths, the (ed, node) pair
// type and its all-ones initial value.
package two_min_pkg;

    localparam int DEF_ED_W   = 16;
    localparam int DEF_NODE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DEF_ED_W-1:0]   ed;
        logic [DEF_NODE_W-1:0] node;
    } pair_t;

    // "Nothing found yet": larger than any real distance, invalid node.
    localparam pair_t PAIR_INIT = '1;

endpackage

// File: rtl/two_min_search_best_two.sv
// rtl/two_min_search_best_two.sv - running smallest/second-smallest (ed, node) tracker
//
// Purpose: keeps the two best (lowest ED) pairs seen since the last clear.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               reload both pairs with all ones (wins over in_valid)
//   in_valid, ed, node  candidate pair to fold into the running result
//   min1_ed/min1_node   smallest ED seen and its node
//   min2_ed/min2_node   second-smallest ED seen and its node
module best_two_tracker
    import two_min_pkg::*;
#(
    parameter int ED_W   = DEF_ED_W,
    parameter int NODE_W = DEF_NODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [ED_W-1:0]   ed,
    input  logic [NODE_W-1:0] node,
    output logic [ED_W-1:0]   min1_ed,
    output logic [NODE_W-1:0] min1_node,
    output logic [ED_W-1:0]   min2_ed,
    output logic [NODE_W-1:0] min2_node
);

    logic [ED_W-1:0]   r_min1_ed;
    logic [NODE_W-1:0] r_min1_node;
    logic [ED_W-1:0]   r_min2_ed;
    logic [NODE_W-1:0] r_min2_node;

    // Strict compares: with nodes presented in ascending order, an equal ED
    // never displaces the earlier node, so ties resolve to the lowest index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min1_ed   <= '1;
            r_min1_node <= '1;
            r_min2_ed   <= '1;
            r_min2_node <= '1;
        end else if (clear) begin
            r_min1_ed   <= '1;
            r_min1_node <= '1;
            r_min2_ed   <= '1;
            r_min2_node <= '1;
        end else if (in_valid) begin
            if (ed < r_min1_ed) begin
                r_min2_ed   <= r_min1_ed;
                r_min2_node <= r_min1_node;
                r_min1_ed   <= ed;
                r_min1_node <= node;
            end else if (ed < r_min2_ed) begin
                r_min2_ed   <= ed;
                r_min2_node <= node;
            end
        end
    end

    assign min1_ed   = r_min1_ed;
    assign min1_node = r_min1_node;
    assign min2_ed   = r_min2_ed;
    assign min2_node = r_min2_node;

endmodule

// File: rtl/two_min_search_ctrl.sv
// rtl/two_min_search_ctrl.sv - sequencer streaming candidate EDs into a best-two tracker
//
// Purpose: on start, reads N EDs from external memory (addr = node index),
// tracks the two smallest and presents them on a valid/ready result port.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start, num_cand              search request and candidate count (IDLE only)
//   abort                        cancel an in-flight search (FETCH/DRAIN only)
//   busy                         not IDLE
//   ed_rd_en, ed_rd_addr         ED memory read strobe/address
//   ed_rd_data                   ED memory data, one cycle after ed_rd_en
//   res_valid, res_ready         result handshake
//   res_min1_*/res_min2_*        smallest / second-smallest ED and node
//   res_err                      search rejected (N out of range)
module two_min_search_ctrl
    import two_min_pkg::*;
#(
    parameter int ED_W   = DEF_ED_W,
    parameter int NODE_W = DEF_NODE_W,
    parameter int CNT_W  = NODE_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_cand,
    input  logic              abort,
    output logic              busy,
    output logic              ed_rd_en,
    output logic [NODE_W-1:0] ed_rd_addr,
    input  logic [ED_W-1:0]   ed_rd_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ED_W-1:0]   res_min1_ed,
    output logic [ED_W-1:0]   res_min2_ed,
    output logic [NODE_W-1:0] res_min1_node,
    output logic [NODE_W-1:0] res_min2_node,
    output logic              res_err
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(2 ** NODE_W);

    state_t            r_state;
    state_t            w_next;
    logic [NODE_W-1:0] r_idx;
    logic [CNT_W-1:0]  r_n_lat;
    logic              r_err;
    logic              r_pv;
    logic [NODE_W-1:0] r_pnode;
    logic              r_res_valid;
    logic              r_res_err;
    logic [ED_W-1:0]   r_res_min1_ed;
    logic [ED_W-1:0]   r_res_min2_ed;
    logic [NODE_W-1:0] r_res_min1_node;
    logic [NODE_W-1:0] r_res_min2_node;

    logic              w_n_ok;
    logic              w_last;
    logic              w_clear;
    logic [ED_W-1:0]   w_min1_ed;
    logic [ED_W-1:0]   w_min2_ed;
    logic [NODE_W-1:0] w_min1_node;
    logic [NODE_W-1:0] w_min2_node;

    assign w_n_ok  = (num_cand != '0) && (num_cand <= MAX_N);
    assign w_last  = (CNT_W'(r_idx) == (r_n_lat - CNT_W'(1)));
    assign w_clear = (r_state == ST_IDLE) && start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = w_n_ok ? ST_FETCH : ST_HOLD;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_last) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_next = abort ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                if (r_res_valid && res_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_idx           <= '0;
            r_n_lat         <= '0;
            r_err           <= 1'b0;
            r_pv            <= 1'b0;
            r_pnode         <= '0;
            r_res_valid     <= 1'b0;
            r_res_err       <= 1'b0;
            r_res_min1_ed   <= '1;
            r_res_min2_ed   <= '1;
            r_res_min1_node <= '1;
            r_res_min2_node <= '1;
        end else begin
            r_state <= w_next;

            // Read pipeline: the node travels with the one-cycle memory latency.
            // An abort kills the read issued in the same cycle.
            r_pv    <= (r_state == ST_FETCH) && !abort;
            r_pnode <= r_idx;

            if ((r_state == ST_FETCH) && !abort && !w_last) begin
                r_idx <= r_idx + NODE_W'(1);
            end else begin
                r_idx <= '0;
            end

            if (w_clear) begin
                r_n_lat <= num_cand;
                r_err   <= !w_n_ok;
            end

            // First HOLD cycle captures the settled tracker; the tracker was
            // cleared at start, so a rejected search captures all ones.
            if (r_state == ST_HOLD) begin
                if (!r_res_valid) begin
                    r_res_valid     <= 1'b1;
                    r_res_err       <= r_err;
                    r_res_min1_ed   <= w_min1_ed;
                    r_res_min2_ed   <= w_min2_ed;
                    r_res_min1_node <= w_min1_node;
                    r_res_min2_node <= w_min2_node;
                end else if (res_ready) begin
                    r_res_valid <= 1'b0;
                    r_res_err   <= 1'b0;
                end
            end
        end
    end

    best_two_tracker #(
        .ED_W   (ED_W),
        .NODE_W (NODE_W)
    ) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .in_valid  (r_pv),
        .ed        (ed_rd_data),
        .node      (r_pnode),
        .min1_ed   (w_min1_ed),
        .min1_node (w_min1_node),
        .min2_ed   (w_min2_ed),
        .min2_node (w_min2_node)
    );

    assign busy          = (r_state != ST_IDLE);
    assign ed_rd_en      = (r_state == ST_FETCH);
    assign ed_rd_addr    = r_idx;
    assign res_valid     = r_res_valid;
    assign res_err       = r_res_err;
    assign res_min1_ed   = r_res_min1_ed;
    assign res_min2_ed   = r_res_min2_ed;
    assign res_min1_node = r_res_min1_node;
    assign res_min2_node = r_res_min2_node;

endmodule

// File: doc/two_min_search_ctrl.md
Name: two_min_search_ctrl

Overview:
- Sequencer for the two-minimum search datapath: on a start pulse it streams N candidate indices to an external Euclidean-distance (ED) memory.
- It feeds the returned EDs, with their node indices, into an internal best-two tracker.
- It presents the smallest and second-smallest ED and their nodes on a valid/ready result port.
- It sits between the tree-search level controller, which issues start and consumes results, and the ED storage.

Parameters:
- ED_W, 16, width of an unsigned Euclidean distance.
- NODE_W, 8, width of a node index; max candidates per search = 2**NODE_W.
- CNT_W, NODE_W+1, width of the candidate-count input.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- num_cand  in  CNT_W  candidate count N, latched with start.
- abort  in  1  cancels an in-flight search.
- busy  out  1  high in any state other than IDLE.
- ed_rd_en  out  1  ED memory read strobe.
- ed_rd_addr  out  NODE_W  ED memory address (= node index).
- ed_rd_data  in  ED_W  read data, valid exactly 1 cycle after ed_rd_en.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_min1_ed, res_min2_ed  out  ED_W  smallest and second-smallest ED.
- res_min1_node, res_min2_node  out  NODE_W  corresponding node indices.
- res_err  out  1  search was rejected (N==0 or N>2**NODE_W).

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, ed_rd_en, res_valid, res_err = 0; ed_rd_addr = 0; all res_* ED/node fields = all ones; read pipeline valid bit cleared.
- States: IDLE, FETCH, DRAIN, HOLD.
- IDLE:
  - start=1 latches N and clears the tracker to all ones (ED and node).
  - If 1 <= N <= 2**NODE_W: go to FETCH with index 0.
  - Otherwise: go to HOLD with res_err=1 and all fields all ones.
- FETCH:
  - Each cycle ed_rd_en=1 and ed_rd_addr=idx; idx increments.
  - After issuing idx N-1, go to DRAIN.
  - A 1-deep pipeline register carries (valid, node) alongside the memory latency.
- DRAIN: one cycle with no read; the last returned datum is absorbed. Then go to HOLD.
- Tracker update, on each cycle the pipeline valid bit is set, with d = ed_rd_data and n = delayed node:
  - If d < min1_ed: min2 <= min1, then min1 <= (d, n).
  - Else if d < min2_ed: min2 <= (d, n).
  - Else: no change.
  - Comparisons are unsigned and strict. Because nodes arrive in ascending order, ties resolve to the lowest index: equal EDs put the earlier node in min1 and the later one in min2.
- HOLD:
  - res_valid=1; res_* fields are registered and held stable until the handshake completes.
  - res_valid & res_ready: go to IDLE on the next edge; res_valid drops and res_err clears.
- Latency: res_valid first asserts N+2 rising edges after the edge that sampled start (FETCH N cycles, DRAIN 1 cycle, HOLD registered).
- N==1: min2 ED and node stay all ones.
- abort in FETCH or DRAIN:
  - Go to IDLE on the next edge; ed_rd_en deasserts that edge and the pipeline valid bit clears.
  - No result is produced and no res_valid pulse occurs.
  - abort in IDLE or HOLD is ignored.
- start while busy is ignored; it is not queued.
- Start in the same cycle as the HOLD handshake is ignored, because the state is not yet IDLE.
- Reset mid-search: immediate return to reset values; any data returned later from memory is discarded.

Decomposition:
- Shared package two_min_pkg:
  - state enum (IDLE/FETCH/DRAIN/HOLD);
  - ED_W/NODE_W defaults;
  - a typedef for the (ed, node) pair;
  - the all-ones init constant.
- One sub-module, best_two_tracker, holding the min1/min2 pair registers:
  - inputs: clk, rst_n, clear, in_valid, ed, node;
  - outputs: the two pairs.
- The top-level module holds the FSM, the index counter, and the read pipeline.

Test Plan:
- N=4, EDs {40,10,30,20} at addr 0..3 -> after 6 edges res_valid=1; min1=(10, node 1), min2=(20, node 3); ed_rd_en high exactly 4 cycles.
- N=3, EDs {7,7,7} -> min1=(7, node 0), min2=(7, node 1); N=1, ED {5} -> min1=(5, 0), min2=(all ones, all ones).
- N=0, and separately N=257 with NODE_W=8 -> HOLD with res_err=1, all fields all ones, no ed_rd_en pulses; N=256 with descending EDs -> min1 node 255, min2 node 254.
- res_ready held low 10 cycles in HOLD with start pulsed -> res fields stable, start ignored; res_ready=1 -> IDLE next edge.
- abort on the 3rd FETCH cycle of N=8 -> IDLE next edge, no res_valid; a following start with N=2, EDs {9,3} -> min1=(3, 1), min2=(9, 0), with no stale data mixed in.
- rst_n low asynchronously mid-DRAIN -> outputs take reset values before the next clk edge; after release, IDLE and busy=0.
